// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle FETCH/DECODE/EXEC/MEM control for the 16-bit datapath.
// Owns the instruction register, issues one-cycle PC commands, resolves branch
// and jump conditions from the ALU flags and drives the shared memory port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_rdata, mem_ack    memory read data and request completion
//   flags                 {N, C, F, Z} registered ALU flags
//   halt_req              stop before the next fetch while high
//   ir                    instruction register
//   mem_req, mem_we       memory request and write strobe (combinational from state)
//   addr_sel              0 = PC address, 1 = register address
//   reg_write, pc_en      register-file write strobe, PC command (one-cycle)
//   halted                high while in HALT
//   retire_cnt            retired-instruction counter, wraps silently
module pc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [3:0]  flags,
  input  logic        halt_req,
  output logic [15:0] ir,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        reg_write,
  output logic [1:0]  pc_en,
  output logic        halted,
  output logic [15:0] retire_cnt
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PC_W    = 2;

  localparam logic [PC_W-1:0] PC_HOLD = 2'b00;
  localparam logic [PC_W-1:0] PC_INC  = 2'b01;
  localparam logic [PC_W-1:0] PC_JUMP = 2'b10;
  localparam logic [PC_W-1:0] PC_ADD  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state, next_state;

  // fetch_busy marks a fetch request already in flight, so halt_req is
  // only honoured in the first FETCH cycle and never cancels a live request.
  logic fetch_busy, next_busy;
  logic ir_load;
  logic req_raw;

  logic [3:0] op, cond, ext;
  logic       is_load, is_stor, is_jcond, is_bcond, taken;
  logic       unused_ir_bits;

  assign op   = ir[15:12];
  assign cond = ir[11:8];
  assign ext  = ir[7:4];
  assign unused_ir_bits = ^ir[3:0];

  // Instruction class decode
  always_comb begin
    is_load  = (op == 4'h4) && (ext == 4'h0);
    is_stor  = (op == 4'h4) && (ext == 4'h4);
    is_jcond = (op == 4'h4) && (ext == 4'hC);
    is_bcond = (op == 4'hC);
  end

  // Condition resolution; flags = {N, C, F, Z}
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'b0000: taken =  flags[0];
      4'b0001: taken = ~flags[0];
      4'b0010: taken =  flags[2];
      4'b0011: taken = ~flags[2];
      4'b0100: taken =  flags[3];
      4'b0101: taken = ~flags[3];
      4'b0110: taken =  flags[1];
      4'b0111: taken = ~flags[1];
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // State register and fetch-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      fetch_busy <= 1'b0;
    end else begin
      state      <= next_state;
      fetch_busy <= next_busy;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    next_state = state;
    next_busy  = 1'b0;
    ir_load    = 1'b0;
    req_raw    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    reg_write  = 1'b0;
    pc_en      = PC_HOLD;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        if (!fetch_busy && halt_req) begin
          next_state = S_HALT;
        end else begin
          req_raw = 1'b1;
          if (mem_ack) begin
            ir_load    = 1'b1;
            next_state = S_DECODE;
          end else begin
            next_busy = 1'b1;
          end
        end
      end
      S_DECODE: begin
        next_state = S_EXEC;
      end
      S_EXEC: begin
        next_state = S_FETCH;
        if (is_load || is_stor) begin
          next_state = S_MEM;
        end else if (is_bcond) begin
          pc_en = taken ? PC_ADD : PC_INC;
        end else if (is_jcond) begin
          pc_en = taken ? PC_JUMP : PC_INC;
        end else begin
          reg_write = 1'b1;
          pc_en     = PC_INC;
        end
      end
      S_MEM: begin
        req_raw  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_stor;
        if (mem_ack) begin
          pc_en      = PC_INC;
          reg_write  = is_load;
          next_state = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) next_state = S_FETCH;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Reset state is FETCH, so the request is masked while rst_n is low.
  assign mem_req = req_raw & rst_n;

  // Instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= INSTR_W'(0);
    end else if (ir_load) begin
      ir <= mem_rdata;
    end
  end

  // Retirement counter: every non-hold PC command retires one instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= CNT_W'(0);
    end else if (pc_en != PC_HOLD) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: drives a memory model cycle by cycle,
// pushes the expected retirement (pc_en, reg_write, mem_we) into a scoreboard
// when each instruction is issued and pops it when the DUT retires.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  flags;
  logic        halt_req;
  logic [15:0] ir;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        reg_write;
  logic [1:0]  pc_en;
  logic        halted;
  logic [15:0] retire_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_retire = 16'h0000;

  typedef struct packed {
    logic [1:0] pc;
    logic       rw;
    logic       we;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_it;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .flags      (flags),
    .halt_req   (halt_req),
    .ir         (ir),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition evaluation; f = {N, C, F, Z}
  function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] f);
    bit n, cy, fl, z;
    n = f[3]; cy = f[2]; fl = f[1]; z = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return fl;
      4'h7: return !fl;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Retirement monitor: every non-hold pc_en must match the scoreboard head
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && pc_en !== 2'b00) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected: pc_en=%b rw=%b we=%b with empty scoreboard",
                 pc_en, reg_write, mem_we);
      end else begin
        mon_it = sb.pop_front();
        if (pc_en !== mon_it.pc || reg_write !== mon_it.rw || mem_we !== mon_it.we) begin
          bad++;
          $display("FAIL retire_strobes: got pc_en=%b rw=%b we=%b want pc_en=%b rw=%b we=%b",
                   pc_en, reg_write, mem_we, mon_it.pc, mon_it.rw, mon_it.we);
        end
      end
    end
  end

  // Runs one instruction from the first FETCH cycle through retirement.
  // Entered and left just after a falling edge with the DUT in FETCH.
  task automatic do_instr(input logic [15:0] instr, input logic [3:0] fl,
                          input int fwait, input int mwait, input bit ack_always,
                          input bit halt_in_exec, input logic [1:0] exp_pc,
                          input bit exp_rw);
    sb_item_t it;
    bit is_mem, is_st;
    is_mem = (instr[15:12] == 4'h4) && (instr[7:4] == 4'h0 || instr[7:4] == 4'h4);
    is_st  = (instr[15:12] == 4'h4) && (instr[7:4] == 4'h4);
    it.pc = exp_pc;
    it.rw = exp_rw;
    it.we = is_st;
    sb.push_back(it);
    flags = fl;
    for (int i = 0; i <= fwait; i++) begin
      mem_ack   = (i == fwait) || ack_always;
      mem_rdata = (i == fwait) ? instr : 16'hDEAD;
      #1;
      total++;
      if (mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0 || pc_en !== 2'b00) begin
        bad++;
        $display("FAIL fetch_phase %h: got req=%b sel=%b we=%b pc_en=%b want 1 0 0 00",
                 instr, mem_req, addr_sel, mem_we, pc_en);
      end
      @(negedge clk);
    end
    mem_ack   = ack_always;
    mem_rdata = 16'hBEEF;
    #1;
    total++;
    if (ir !== instr || mem_req !== 1'b0 || pc_en !== 2'b00 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL decode_phase: got ir=%h req=%b pc_en=%b rw=%b want ir=%h 0 00 0",
               ir, mem_req, pc_en, reg_write, instr);
    end
    @(negedge clk);
    if (halt_in_exec) halt_req = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL exec_phase %h: got req=%b halted=%b want 0 0", instr, mem_req, halted);
    end
    @(negedge clk);
    if (is_mem) begin
      for (int i = 0; i <= mwait; i++) begin
        mem_ack = (i == mwait);
        #1;
        total++;
        if (mem_req !== 1'b1 || addr_sel !== 1'b1 || mem_we !== is_st) begin
          bad++;
          $display("FAIL mem_phase %h cyc%0d: got req=%b sel=%b we=%b want 1 1 %b",
                   instr, i, mem_req, addr_sel, mem_we, is_st);
        end
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    exp_retire = exp_retire + 16'd1;
    #1;
    total++;
    if (retire_cnt !== exp_retire) begin
      bad++;
      $display("FAIL retire_cnt %h: got %h want %h", instr, retire_cnt, exp_retire);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234; flags = 4'h0; halt_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (ir !== 16'h0 || retire_cnt !== 16'h0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        addr_sel !== 1'b0 || reg_write !== 1'b0 || pc_en !== 2'b00 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ir=%h cnt=%h req=%b we=%b sel=%b rw=%b pc=%b hlt=%b want all 0",
               ir, retire_cnt, mem_req, mem_we, addr_sel, reg_write, pc_en, halted);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_fetch: got req=%b sel=%b want 1 0", mem_req, addr_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    do_instr(16'h0312, 4'h0, 0, 0, 1'b1, 1'b0, 2'b01, 1'b1);
    do_instr(16'h4310, 4'hF, 2, 0, 1'b0, 1'b0, 2'b01, 1'b1);
  endtask

  task automatic test_bcond();
    do_instr(16'hC005, 4'b0001, 0, 0, 1'b0, 1'b0, 2'b11, 1'b0);
    do_instr(16'hC005, 4'b0000, 1, 0, 1'b0, 1'b0, 2'b01, 1'b0);
  endtask

  task automatic test_jcond();
    do_instr(16'h4EC0, 4'h0, 0, 0, 1'b0, 1'b0, 2'b10, 1'b0);
    do_instr(16'h4FC0, 4'hF, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0);
    do_instr(16'h44C0, 4'b1000, 0, 0, 1'b0, 1'b0, 2'b10, 1'b0);
  endtask

  task automatic test_cond_sweep();
    logic [3:0] fl;
    logic [3:0] c;
    for (int k = 0; k < 16; k++) begin
      c  = 4'(k);
      fl = 4'($urandom_range(0, 15));
      do_instr({4'hC, c, 8'h3A}, fl, k % 2, 0, 1'b0, 1'b0,
               ref_taken(c, fl) ? 2'b11 : 2'b01, 1'b0);
      do_instr({4'h4, c, 8'hC7}, ~fl, 0, 0, 1'b0, 1'b0,
               ref_taken(c, ~fl) ? 2'b10 : 2'b01, 1'b0);
    end
  endtask

  task automatic test_load_stor();
    do_instr(16'h4300, 4'h0, 0, 3, 1'b0, 1'b0, 2'b01, 1'b1);
    do_instr(16'h4340, 4'h0, 0, 3, 1'b0, 1'b0, 2'b01, 1'b0);
    do_instr(16'h4100, 4'h0, 0, 0, 1'b1, 1'b0, 2'b01, 1'b1);
  endtask

  task automatic test_halt();
    do_instr(16'h1234, 4'h0, 0, 0, 1'b0, 1'b1, 2'b01, 1'b1);
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL halt_no_fetch: got req=%b want 0", mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc_en !== 2'b00) begin
        bad++;
        $display("FAIL halt_hold cyc%0d: got halted=%b req=%b pc_en=%b want 1 0 00",
                 i, halted, mem_req, pc_en);
      end
    end
    halt_req = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || addr_sel !== 1'b0) begin
      bad++;
      $display("FAIL halt_resume: got halted=%b req=%b sel=%b want 0 1 0",
               halted, mem_req, addr_sel);
    end
    do_instr(16'h2222, 4'h0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1);
  endtask

  task automatic test_reset_mid_mem();
    mem_rdata = 16'h4500; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b1) begin
      bad++;
      $display("FAIL mid_mem_req: got req=%b sel=%b want 1 1", mem_req, addr_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_retire = 16'h0000;
    total++;
    if (mem_req !== 1'b0 || addr_sel !== 1'b0 || ir !== 16'h0 || retire_cnt !== 16'h0 ||
        reg_write !== 1'b0 || pc_en !== 2'b00) begin
      bad++;
      $display("FAIL async_reset: req=%b sel=%b ir=%h cnt=%h rw=%b pc=%b want all 0",
               mem_req, addr_sel, ir, retire_cnt, reg_write, pc_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_fetch: got req=%b sel=%b we=%b want 1 0 0",
               mem_req, addr_sel, mem_we);
    end
    do_instr(16'h0312, 4'h0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1);
  endtask

  task automatic test_wrap();
    mem_ack = 1'b0;
    force dut.retire_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.retire_cnt;
    #1;
    total++;
    if (retire_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want FFFF", retire_cnt);
    end
    exp_retire = 16'hFFFF;
    do_instr(16'h0312, 4'h0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1);
    total++;
    if (retire_cnt !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_zero: got %h want 0000", retire_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_instr(16'h0AB1, 4'h0, 0, 0, 1'b1, 1'b0, 2'b01, 1'b1);
    do_instr(16'h4200, 4'h0, 1, 2, 1'b0, 1'b0, 2'b01, 1'b1);
    do_instr(16'hC1FF, 4'b0000, 0, 0, 1'b0, 1'b0, 2'b11, 1'b0);
    do_instr(16'h4740, 4'h0, 2, 1, 1'b0, 1'b0, 2'b01, 1'b0);
    do_instr(16'h46C0, 4'b0010, 0, 0, 1'b1, 1'b0, 2'b10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bcond();
    test_jcond();
    test_cond_sweep();
    test_load_stor();
    test_halt();
    test_reset_mid_mem();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d retirements missing, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
